// File: rtl/id_ex_stage_reg_pkg.sv
// Shared encodings for the ID/EX boundary: ALU commands and the control bundle
// that a bubble or flush squashes.
package id_ex_stage_reg_pkg;

  typedef enum logic [3:0] {
    ALU_NONE = 4'b0000,
    ALU_MOV  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_ADC  = 4'b0011,
    ALU_SUB  = 4'b0100,
    ALU_SBC  = 4'b0101,
    ALU_AND  = 4'b0110,
    ALU_ORR  = 4'b0111,
    ALU_EOR  = 4'b1000,
    ALU_MVN  = 4'b1001
  } alu_cmd_e;

  typedef struct packed {
    logic [3:0] alu_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       status_en;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Control bits only survive when the slot holds a real instruction.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic keep);
    return keep ? c : CTRL_NOP;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Enable-gated up counter that sticks at all-ones; synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)                    count <= '0;
    else if (en && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with freeze, flush and bubble insertion, plus a
// saturating count of squashed slots for performance visibility.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  bubble,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [3:0]            id_alu_cmd,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_wb_en,
  input  logic                  id_branch,
  input  logic                  id_status_en,
  input  logic [DATA_W-1:0]     id_val_rn,
  input  logic [DATA_W-1:0]     id_val_rm,
  input  logic                  id_imm,
  input  logic [11:0]           id_shift_operand,
  input  logic [23:0]           id_signed_imm_24,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_carry,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [3:0]            ex_alu_cmd,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_wb_en,
  output logic                  ex_branch,
  output logic                  ex_status_en,
  output logic [DATA_W-1:0]     ex_val_rn,
  output logic [DATA_W-1:0]     ex_val_rm,
  output logic                  ex_imm,
  output logic [11:0]           ex_shift_operand,
  output logic [23:0]           ex_signed_imm_24,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [REG_ADDR_W-1:0] ex_src1,
  output logic [REG_ADDR_W-1:0] ex_src2,
  output logic                  ex_carry,
  output logic [CNT_W-1:0]      bubble_count
);

  ctrl_t id_ctrl, ex_ctrl;
  logic  cnt_en;

  assign id_ctrl = '{alu_cmd:   id_alu_cmd,
                     mem_read:  id_mem_read,
                     mem_write: id_mem_write,
                     wb_en:     id_wb_en,
                     branch:    id_branch,
                     status_en: id_status_en};

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid         <= 1'b0;
      ex_ctrl          <= CTRL_NOP;
      ex_pc            <= '0;
      ex_val_rn        <= '0;
      ex_val_rm        <= '0;
      ex_imm           <= 1'b0;
      ex_shift_operand <= '0;
      ex_signed_imm_24 <= '0;
      ex_dest          <= '0;
      ex_src1          <= '0;
      ex_src2          <= '0;
      ex_carry         <= 1'b0;
    end else if (!freeze) begin
      if (flush) begin
        // Squashed slot carries no data at all.
        ex_valid         <= 1'b0;
        ex_ctrl          <= CTRL_NOP;
        ex_pc            <= '0;
        ex_val_rn        <= '0;
        ex_val_rm        <= '0;
        ex_imm           <= 1'b0;
        ex_shift_operand <= '0;
        ex_signed_imm_24 <= '0;
        ex_dest          <= '0;
        ex_src1          <= '0;
        ex_src2          <= '0;
        ex_carry         <= 1'b0;
      end else begin
        // Bubble keeps the data so forwarding compares stay benign (wb_en=0).
        ex_valid         <= id_valid && !bubble;
        ex_ctrl          <= gate_ctrl(id_ctrl, id_valid && !bubble);
        ex_pc            <= id_pc;
        ex_val_rn        <= id_val_rn;
        ex_val_rm        <= id_val_rm;
        ex_imm           <= id_imm;
        ex_shift_operand <= id_shift_operand;
        ex_signed_imm_24 <= id_signed_imm_24;
        ex_dest          <= id_dest;
        ex_src1          <= id_src1;
        ex_src2          <= id_src2;
        ex_carry         <= id_carry;
      end
    end
  end

  assign ex_alu_cmd   = ex_ctrl.alu_cmd;
  assign ex_mem_read  = ex_ctrl.mem_read;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_wb_en     = ex_ctrl.wb_en;
  assign ex_branch    = ex_ctrl.branch;
  assign ex_status_en = ex_ctrl.status_en;

  // flush+bubble in one cycle counts once.
  assign cnt_en = !freeze && (flush || bubble);

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (cnt_en),
    .count (bubble_count)
  );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: cycle-by-cycle model compare plus
// hand-computed spot checks; a second instance with a 4-bit counter covers saturation.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  alu;
    logic        mem_read;
    logic        mem_write;
    logic        wb_en;
    logic        branch;
    logic        status_en;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        carry;
  } bun_t;

  logic clk = 1'b0;
  logic rst, freeze, flush, bubble;
  bun_t id, act, act_s, exp_b;
  int   exp_c16, exp_c4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  logic chk_en = 1'b0;
  int   nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
    .id_valid(id.valid), .id_pc(id.pc), .id_alu_cmd(id.alu),
    .id_mem_read(id.mem_read), .id_mem_write(id.mem_write), .id_wb_en(id.wb_en),
    .id_branch(id.branch), .id_status_en(id.status_en),
    .id_val_rn(id.rn), .id_val_rm(id.rm), .id_imm(id.imm),
    .id_shift_operand(id.shop), .id_signed_imm_24(id.simm),
    .id_dest(id.dest), .id_src1(id.src1), .id_src2(id.src2), .id_carry(id.carry),
    .ex_valid(act.valid), .ex_pc(act.pc), .ex_alu_cmd(act.alu),
    .ex_mem_read(act.mem_read), .ex_mem_write(act.mem_write), .ex_wb_en(act.wb_en),
    .ex_branch(act.branch), .ex_status_en(act.status_en),
    .ex_val_rn(act.rn), .ex_val_rm(act.rm), .ex_imm(act.imm),
    .ex_shift_operand(act.shop), .ex_signed_imm_24(act.simm),
    .ex_dest(act.dest), .ex_src1(act.src1), .ex_src2(act.src2), .ex_carry(act.carry),
    .bubble_count(cnt16)
  );

  id_ex_stage_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
    .id_valid(id.valid), .id_pc(id.pc), .id_alu_cmd(id.alu),
    .id_mem_read(id.mem_read), .id_mem_write(id.mem_write), .id_wb_en(id.wb_en),
    .id_branch(id.branch), .id_status_en(id.status_en),
    .id_val_rn(id.rn), .id_val_rm(id.rm), .id_imm(id.imm),
    .id_shift_operand(id.shop), .id_signed_imm_24(id.simm),
    .id_dest(id.dest), .id_src1(id.src1), .id_src2(id.src2), .id_carry(id.carry),
    .ex_valid(act_s.valid), .ex_pc(act_s.pc), .ex_alu_cmd(act_s.alu),
    .ex_mem_read(act_s.mem_read), .ex_mem_write(act_s.mem_write), .ex_wb_en(act_s.wb_en),
    .ex_branch(act_s.branch), .ex_status_en(act_s.status_en),
    .ex_val_rn(act_s.rn), .ex_val_rm(act_s.rm), .ex_imm(act_s.imm),
    .ex_shift_operand(act_s.shop), .ex_signed_imm_24(act_s.simm),
    .ex_dest(act_s.dest), .ex_src1(act_s.src1), .ex_src2(act_s.src2), .ex_carry(act_s.carry),
    .bubble_count(cnt4)
  );

  task automatic chk(input string name, input logic [255:0] a, input logic [255:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  // Model: what the stage must hold after an edge, from the mode rules.
  function automatic bun_t model_next(bun_t cur, bun_t in, logic r, logic fz, logic fl, logic bb);
    bun_t n;
    if (r)       n = '0;
    else if (fz) n = cur;
    else if (fl) n = '0;
    else begin
      n = in;
      if (bb || !in.valid) begin
        n.valid = 1'b0; n.alu = 4'd0; n.mem_read = 1'b0; n.mem_write = 1'b0;
        n.wb_en = 1'b0; n.branch = 1'b0; n.status_en = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    exp_b <= model_next(exp_b, id, rst, freeze, flush, bubble);
    if (rst) begin
      exp_c16 <= 0; exp_c4 <= 0; chk_en <= 1'b1;
    end else if (!freeze && (flush || bubble)) begin
      exp_c16 <= (exp_c16 < 65535) ? exp_c16 + 1 : 65535;
      exp_c4  <= (exp_c4 < 15) ? exp_c4 + 1 : 15;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_bundle", 256'(act), 256'(exp_b));
      chk("ex_bundle_sat_inst", 256'(act_s), 256'(exp_b));
      chk("bubble_count", 256'(cnt16), 256'(exp_c16));
      chk("bubble_count_w4", 256'(cnt4), 256'(exp_c4));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [3:0] alu, input logic mr,
                           input logic mw, input logic wb, input logic [31:0] rn,
                           input logic [31:0] rm, input logic [3:0] dest);
    id = '0;
    id.valid = 1'b1; id.pc = pc; id.alu = alu; id.mem_read = mr; id.mem_write = mw;
    id.wb_en = wb; id.rn = rn; id.rm = rm; id.dest = dest;
    id.src1 = 4'd1; id.src2 = 4'd2; id.shop = 12'hA5C; id.simm = 24'h80_1234;
    id.imm = 1'b1; id.carry = 1'b1; id.status_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; bubble = 1'b0; id = '0;
    id.pc = 32'hDEAD_BEEF; id.valid = 1'b1; id.wb_en = 1'b1;
    tick(); tick();
    chk("rst_ex_pc", 256'(act.pc), 256'(0));
    chk("rst_ex_valid", 256'(act.valid), 256'(0));
    chk("rst_ex_wb_en", 256'(act.wb_en), 256'(0));
    chk("rst_count", 256'(cnt16), 256'(0));

    // ADD
    rst = 1'b0;
    set_instr(32'h4, 4'b0010, 0, 0, 1, 32'd5, 32'd7, 4'd3);
    tick();
    chk("add_alu", 256'(act.alu), 256'(4'b0010));
    chk("add_wb_en", 256'(act.wb_en), 256'(1));
    chk("add_rn", 256'(act.rn), 256'(5));
    chk("add_rm", 256'(act.rm), 256'(7));
    chk("add_dest", 256'(act.dest), 256'(3));
    chk("add_valid", 256'(act.valid), 256'(1));

    // LDR then freeze for 3 cycles while ID moves on
    set_instr(32'h10, 4'b0010, 1, 0, 1, 32'd100, 32'd8, 4'd6);
    tick();
    freeze = 1'b1; id.pc = 32'h14;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_pc", 256'(act.pc), 256'(32'h10));
      chk("frz_mem_read", 256'(act.mem_read), 256'(1));
    end
    freeze = 1'b0;
    tick();
    chk("unfrz_pc", 256'(act.pc), 256'(32'h14));

    // STR squashed by flush
    set_instr(32'h18, 4'b0010, 0, 1, 0, 32'd1, 32'd2, 4'd7);
    flush = 1'b1;
    tick();
    chk("flush_mem_write", 256'(act.mem_write), 256'(0));
    chk("flush_valid", 256'(act.valid), 256'(0));
    chk("flush_pc", 256'(act.pc), 256'(0));
    chk("flush_count", 256'(cnt16), 256'(1));

    // MOV turned into a bubble
    flush = 1'b0; bubble = 1'b1;
    set_instr(32'h1C, 4'b0001, 0, 0, 1, 32'd0, 32'd9, 4'd4);
    tick();
    chk("bub_wb_en", 256'(act.wb_en), 256'(0));
    chk("bub_alu", 256'(act.alu), 256'(0));
    chk("bub_dest", 256'(act.dest), 256'(4));
    chk("bub_rm", 256'(act.rm), 256'(9));
    chk("bub_count", 256'(cnt16), 256'(2));

    // freeze beats flush and bubble
    freeze = 1'b1; flush = 1'b1; bubble = 1'b1;
    set_instr(32'h20, 4'b0110, 1, 1, 1, 32'd11, 32'd12, 4'd9);
    tick();
    chk("prio_frz_dest", 256'(act.dest), 256'(4));
    chk("prio_frz_rm", 256'(act.rm), 256'(9));
    chk("prio_frz_count", 256'(cnt16), 256'(2));
    freeze = 1'b0;
    tick();
    chk("prio_fl_bub_count", 256'(cnt16), 256'(3));
    chk("prio_fl_bub_dest", 256'(act.dest), 256'(0));
    // reset beats freeze
    set_instr(32'h24, 4'b0100, 0, 0, 1, 32'd3, 32'd4, 4'd2);
    tick();
    rst = 1'b1; freeze = 1'b1; flush = 1'b0; bubble = 1'b0;
    tick();
    chk("rst_frz_pc", 256'(act.pc), 256'(0));
    chk("rst_frz_count", 256'(cnt16), 256'(0));
    rst = 1'b0; freeze = 1'b0;

    // id_valid=0 strips controls, keeps data, no count
    set_instr(32'h28, 4'b0011, 1, 1, 1, 32'd21, 32'd22, 4'd5);
    id.branch = 1'b1; id.valid = 1'b0;
    tick();
    chk("inv_wb_en", 256'(act.wb_en), 256'(0));
    chk("inv_branch", 256'(act.branch), 256'(0));
    chk("inv_dest", 256'(act.dest), 256'(5));
    chk("inv_count", 256'(cnt16), 256'(0));

    // 20 bubbles: 4-bit counter sticks at 15
    bubble = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_w4", 256'(cnt4), 256'(15));
    chk("sat_w16", 256'(cnt16), 256'(20));
    bubble = 1'b0;
    set_instr(32'h2C, 4'b1000, 0, 0, 1, 32'd1, 32'd1, 4'd1);
    tick();
    chk("sat_w4_after_load", 256'(cnt4), 256'(15));

    // random mix, checked by the model every cycle
    for (int i = 0; i < 200; i++) begin
      id = bun_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 4) == 0);
      bubble = ($urandom_range(0, 3) == 0);
      rst    = ($urandom_range(0, 40) == 0);
      tick();
    end
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; bubble = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
Pipeline register between the ID stage (register file read plus control unit) and the EX stage (ALU, condition/status path).
- Captures every decoded control bit and every operand value on each clk edge.
- Supports three modes: pipeline-wide freeze (memory stall), flush (taken branch in EX), and bubble insertion (hazard unit).
- Keeps a valid bit and a saturating bubble counter for debug and performance visibility.

Parameters:
DATA_W, 32, width of PC and operand values
REG_ADDR_W, 4, register-file address width
CNT_W, 16, width of the bubble counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
freeze  input  1  hold all outputs (memory stall)
flush  input  1  taken branch in EX; squash the ID instruction
bubble  input  1  hazard detected; insert a NOP into EX
id_valid  input  1  ID holds a real instruction
id_pc  input  DATA_W  PC+4 of the ID instruction
id_alu_cmd  input  4  ALU command from control unit
id_mem_read, id_mem_write, id_wb_en, id_branch, id_status_en  input  1 each  control bits
id_val_rn, id_val_rm  input  DATA_W  register operands
id_imm  input  1  immediate-operand flag
id_shift_operand  input  12  shifter operand field
id_signed_imm_24  input  24  branch offset
id_dest, id_src1, id_src2  input  REG_ADDR_W each  destination and source register addresses
id_carry  input  1  current C flag from status register
ex_*  output  same widths  registered copy of every id_* input above (ex_valid, ex_pc, ex_alu_cmd, ...)
bubble_count  output  CNT_W  number of bubbles/flushes inserted since reset

Behaviour:
- All outputs are registered. Latency is 1 cycle from id_* to ex_*. No combinational input-to-output path.
- Per-edge priority: rst > freeze > flush > bubble > normal load.
- rst: every ex_* output and bubble_count go to 0. A reset mid-operation discards the captured instruction.
- freeze=1: every register, including bubble_count, holds its value. flush and bubble are ignored that cycle. The requester keeps flush asserted because the branch stays in EX.
- flush=1 (no freeze):
  - Control fields ex_alu_cmd, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_status_en and ex_valid go to 0.
  - Data fields go to 0.
  - bubble_count increments.
- bubble=1 (no freeze, no flush):
  - Control fields and ex_valid go to 0.
  - Data fields load normally, so forwarding comparisons stay harmless because ex_wb_en=0.
  - bubble_count increments.
- Normal load: all ex_* <= id_*.
- If id_valid=0 on a normal load, control fields are forced to 0 regardless of id_* values; bubble_count does not increment.
- bubble_count saturates at all-ones and never wraps.
- flush+bubble together: flush semantics apply, with a single increment.

Decomposition:
- Shared package: ALU command encodings (MOV 0001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MVN 1001), and a control-bundle struct {alu_cmd, mem_read, mem_write, wb_en, branch, status_en} with a NOP constant of all zero.
- One natural sub-module: sat_counter (enable, saturating, synchronous clear), which holds bubble_count.

Test Plan:
- Reset then load: rst=1 for 2 cycles, all ex_* = 0. Release, drive ADD (alu_cmd=0010, wb_en=1, val_rn=5, val_rm=7, dest=3, id_valid=1). Next cycle ex_alu_cmd=0010, ex_wb_en=1, ex_val_rn=5, ex_val_rm=7, ex_dest=3, ex_valid=1.
- Freeze: load pc=0x10 with LDR controls, assert freeze 3 cycles while id_* changes to pc=0x14. ex_pc stays 0x10 and mem_read=1 throughout; after release ex_pc=0x14 one cycle later.
- Flush: drive STR (mem_write=1) with flush=1. Next cycle ex_mem_write=0, ex_valid=0, ex_pc=0, bubble_count=1.
- Bubble: drive MOV dest=4, val_rm=9 with bubble=1. Next cycle ex_wb_en=0, ex_alu_cmd=0, ex_dest=4, ex_val_rm=9, bubble_count increments by 1.
- Priority: freeze+flush+bubble all 1. Outputs and bubble_count unchanged. Then flush+bubble only gives one increment. rst together with freeze gives all zero.
- Saturation: CNT_W=4 override, 20 consecutive bubbles. bubble_count stops at 15 and stays there; a normal load leaves it at 15.
